// File: rtl/tpu_pkg.sv
// Shared types and phase-length helpers for the systolic-array sequencer,
// used by the RTL, the array wrapper and the bench.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_C = 3'd1,
        MAC    = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } tpu_seq_state_e;

    function automatic int unsigned load_len(input int unsigned dim);
        return dim;
    endfunction

    function automatic int unsigned mac_len(input int unsigned dim);
        return (32'd3 * dim) - 32'd2;
    endfunction

    function automatic int unsigned drain_len(input int unsigned dim);
        return dim;
    endfunction

endpackage

// File: rtl/tpu_skew_mask.sv
// Diagonal feed window: bit r is set while r <= t < r+DIM and the phase is active.
module tpu_skew_mask #(
    parameter int DIM   = 4,
    parameter int CNT_W = $clog2(3*DIM)
) (
    input  logic [CNT_W-1:0] t,
    input  logic             active,
    output logic [DIM-1:0]   mask
);

    localparam int TW = CNT_W + 1;

    logic [TW-1:0] t_ext_s;

    assign t_ext_s = {1'b0, t};

    // Per-row window compare; one extra bit keeps r+DIM from overflowing.
    always_comb begin
        mask = '0;
        for (int r = 0; r < DIM; r++) begin
            if (active && (t_ext_s >= TW'(r)) && (t_ext_s < TW'(r + DIM))) begin
                mask[r] = 1'b1;
            end else begin
                mask[r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tpu_seq.sv
// Tile sequencer for a DIM x DIM tpumac array: LOAD_C, MAC and DRAIN phases
// with shared en/WrEn, skew masks and C-buffer row indices.
module tpu_seq
    import tpu_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int CNT_W = $clog2(3*DIM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    acc,
    input  logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic                    en_o,
    output logic                    WrEn_o,
    output logic [CNT_W-1:0]        step,
    output logic                    c_zero,
    output logic [$clog2(DIM)-1:0]  c_load_row,
    output logic [DIM-1:0]          a_valid,
    output logic [DIM-1:0]          b_valid,
    output logic                    c_out_valid,
    output logic [$clog2(DIM)-1:0]  c_out_row
);

    localparam int RW = $clog2(DIM);

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(load_len(DIM)  - 32'd1);
    localparam logic [CNT_W-1:0] MAC_LAST   = CNT_W'(mac_len(DIM)   - 32'd1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_len(DIM) - 32'd1);
    localparam logic [RW-1:0]    ROW_LAST   = RW'(DIM - 1);

    tpu_seq_state_e   state_r;
    tpu_seq_state_e   state_nxt_s;
    logic [CNT_W-1:0] t_r;
    logic [CNT_W-1:0] t_nxt_s;
    logic             acc_q_r;
    logic             acc_nxt_s;
    logic             mac_active_s;
    logic [RW-1:0]    rev_row_s;

    // Next-state and step counter; a stall freezes both, including on a phase's last step.
    always_comb begin
        state_nxt_s = state_r;
        t_nxt_s     = t_r;
        acc_nxt_s   = acc_q_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD_C;
                    t_nxt_s     = '0;
                    acc_nxt_s   = acc;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_C: begin
                if (stall) begin
                    t_nxt_s = t_r;
                end else if (t_r == LOAD_LAST) begin
                    state_nxt_s = MAC;
                    t_nxt_s     = '0;
                end else begin
                    t_nxt_s = t_r + CNT_W'(1);
                end
            end
            MAC: begin
                if (stall) begin
                    t_nxt_s = t_r;
                end else if (t_r == MAC_LAST) begin
                    state_nxt_s = DRAIN;
                    t_nxt_s     = '0;
                end else begin
                    t_nxt_s = t_r + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (stall) begin
                    t_nxt_s = t_r;
                end else if (t_r == DRAIN_LAST) begin
                    state_nxt_s = DONE;
                    t_nxt_s     = '0;
                end else begin
                    t_nxt_s = t_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                t_nxt_s     = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                t_nxt_s     = '0;
                acc_nxt_s   = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            t_r     <= '0;
            acc_q_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            t_r     <= t_nxt_s;
            acc_q_r <= acc_nxt_s;
        end
    end

    // C rows enter and leave bottom-row first, so the row index counts down.
    assign rev_row_s    = ROW_LAST - t_r[RW-1:0];
    assign mac_active_s = (state_r == MAC);
    assign step         = t_r;

    tpu_skew_mask #(.DIM(DIM), .CNT_W(CNT_W)) u_a_mask (
        .t      (t_r),
        .active (mac_active_s),
        .mask   (a_valid)
    );

    tpu_skew_mask #(.DIM(DIM), .CNT_W(CNT_W)) u_b_mask (
        .t      (t_r),
        .active (mac_active_s),
        .mask   (b_valid)
    );

    // Array controls; stall only gates en and the drain strobe, not WrEn.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        en_o        = 1'b0;
        WrEn_o      = 1'b0;
        c_zero      = 1'b0;
        c_load_row  = '0;
        c_out_valid = 1'b0;
        c_out_row   = '0;
        case (state_r)
            LOAD_C: begin
                busy       = 1'b1;
                en_o       = !stall;
                WrEn_o     = 1'b1;
                c_zero     = !acc_q_r;
                c_load_row = rev_row_s;
            end
            MAC: begin
                busy = 1'b1;
                en_o = !stall;
            end
            DRAIN: begin
                busy        = 1'b1;
                en_o        = !stall;
                WrEn_o      = 1'b1;
                c_out_valid = !stall;
                c_out_row   = rev_row_s;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tpu_seq.sv
// Bench for tpu_seq: step-count reference model plus a 4x4 tpumac array model,
// with scoreboards for the per-cycle controls and the drained C rows.
module tb_tpu_seq;

    localparam int DIM   = 4;
    localparam int CNT_W = $clog2(3*DIM);
    localparam int RW    = $clog2(DIM);
    localparam int MACN  = 3*DIM - 2;
    localparam int OPN   = DIM + MACN + DIM;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             acc;
    logic             stall;
    logic             busy;
    logic             done;
    logic             en_o;
    logic             WrEn_o;
    logic [CNT_W-1:0] step;
    logic             c_zero;
    logic [RW-1:0]    c_load_row;
    logic [DIM-1:0]   a_valid;
    logic [DIM-1:0]   b_valid;
    logic             c_out_valid;
    logic [RW-1:0]    c_out_row;

    tpu_seq #(.DIM(DIM), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .acc         (acc),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .en_o        (en_o),
        .WrEn_o      (WrEn_o),
        .step        (step),
        .c_zero      (c_zero),
        .c_load_row  (c_load_row),
        .a_valid     (a_valid),
        .b_valid     (b_valid),
        .c_out_valid (c_out_valid),
        .c_out_row   (c_out_row)
    );

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             en;
        logic             wren;
        logic [CNT_W-1:0] step;
        logic             c_zero;
        logic [RW-1:0]    c_load_row;
        logic [DIM-1:0]   a_valid;
        logic [DIM-1:0]   b_valid;
        logic             c_out_valid;
        logic [RW-1:0]    c_out_row;
    } ctl_t;

    typedef struct packed {
        logic [RW-1:0]          row;
        logic [DIM-1:0][15:0]   val;
    } row_t;

    ctl_t exp_q[$];
    row_t row_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Operand matrices for the op in flight.
    logic signed [7:0]  ma [DIM][DIM];
    logic signed [7:0]  mb [DIM][DIM];
    logic signed [15:0] mc [DIM][DIM];

    // Reference model: 0 idle, 1 running (k steps consumed), 2 done.
    int   m_mode = 0;
    int   m_k    = 0;
    logic m_acc  = 1'b0;

    // tpumac array model and wrapper inputs snapshotted mid-cycle.
    logic signed [7:0]  ar [DIM][DIM];
    logic signed [7:0]  br [DIM][DIM];
    logic signed [15:0] cr [DIM][DIM];
    logic signed [7:0]  s_ain [DIM];
    logic signed [7:0]  s_bin [DIM];
    logic signed [15:0] s_cin [DIM];
    logic               s_en   = 1'b0;
    logic               s_wren = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic new_op(input logic a);
        row_t e;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                ma[r][c] = 8'($urandom);
                mb[r][c] = 8'($urandom);
                mc[r][c] = 16'($urandom);
            end
        end
        for (int r = DIM - 1; r >= 0; r--) begin
            e.row = RW'(r);
            for (int c = 0; c < DIM; c++) begin
                int s;
                s = a ? int'(mc[r][c]) : 0;
                for (int k = 0; k < DIM; k++) s += int'(ma[r][k]) * int'(mb[k][c]);
                e.val[c] = 16'(s);
            end
            row_q.push_back(e);
        end
    endtask

    task automatic model_edge();
        case (m_mode)
            0: if (start) begin
                m_mode = 1;
                m_k    = 0;
                m_acc  = acc;
                new_op(acc);
            end
            1: if (!stall) begin
                m_k++;
                if (m_k == OPN) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
    endtask

    function automatic ctl_t model_out(input logic sl);
        ctl_t e;
        int   t;
        e = '0;
        if (m_mode == 2) begin
            e.busy = 1'b1;
            e.done = 1'b1;
        end else if (m_mode == 1) begin
            e.busy = 1'b1;
            e.en   = !sl;
            if (m_k < DIM) begin
                e.wren       = 1'b1;
                e.step       = CNT_W'(m_k);
                e.c_zero     = !m_acc;
                e.c_load_row = RW'(DIM - 1 - m_k);
            end else if (m_k < DIM + MACN) begin
                t = m_k - DIM;
                e.step = CNT_W'(t);
                for (int r = 0; r < DIM; r++) begin
                    e.a_valid[r] = (t >= r) && (t < r + DIM);
                    e.b_valid[r] = (t >= r) && (t < r + DIM);
                end
            end else begin
                t = m_k - DIM - MACN;
                e.wren        = 1'b1;
                e.step        = CNT_W'(t);
                e.c_out_valid = !sl;
                e.c_out_row   = RW'(DIM - 1 - t);
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic st, input logic sl, input logic ac);
        start = st;
        stall = sl;
        acc   = ac;
        exp_q.push_back(model_out(sl));
        cyc++;
    endtask

    function automatic logic signed [7:0] a_at(input int r, input int c);
        if (c == 0) return s_ain[r];
        else        return ar[r][c-1];
    endfunction

    function automatic logic signed [7:0] b_at(input int r, input int c);
        if (r == 0) return s_bin[c];
        else        return br[r-1][c];
    endfunction

    function automatic logic signed [15:0] c_at(input int r, input int c);
        if (r == 0) return s_cin[c];
        else        return cr[r-1][c];
    endfunction

    // Array model: every cell shifts A right, B down; C shifts down or accumulates.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && s_en) begin
                for (int r = 0; r < DIM; r++) begin
                    for (int c = 0; c < DIM; c++) begin
                        ar[r][c] <= a_at(r, c);
                        br[r][c] <= b_at(r, c);
                        cr[r][c] <= s_wren ? c_at(r, c) : 16'(cr[r][c] + a_at(r, c) * b_at(r, c));
                    end
                end
            end
        end
    end

    // Monitor: compare controls each cycle, drained rows on c_out_valid, snapshot wrapper inputs.
    initial begin
        ctl_t                 act;
        ctl_t                 e;
        row_t                 re;
        row_t                 got;
        int                   idx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_en = 1'b0;
            end else begin
                act = '{busy, done, en_o, WrEn_o, step, c_zero, c_load_row,
                        a_valid, b_valid, c_out_valid, c_out_row};
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL ctl cycle %0d: got %h expected %h", cyc, act, e);
                    end
                end
                if (c_out_valid) begin
                    n_vec++;
                    got.row = c_out_row;
                    for (int c = 0; c < DIM; c++) got.val[c] = cr[DIM-1][c];
                    if (row_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL row_unexpected cycle %0d: got %h expected none", cyc, got);
                    end else begin
                        re = row_q.pop_front();
                        if (got !== re) begin
                            n_bad++;
                            $display("FAIL row cycle %0d: got %h expected %h", cyc, got, re);
                        end
                    end
                end
                s_en   = en_o;
                s_wren = WrEn_o;
                for (int i = 0; i < DIM; i++) begin
                    idx = int'(step) - i;
                    s_ain[i] = (a_valid[i] && idx >= 0 && idx < DIM) ? ma[i][idx] : 8'sd0;
                    s_bin[i] = (b_valid[i] && idx >= 0 && idx < DIM) ? mb[idx][i] : 8'sd0;
                    s_cin[i] = c_zero ? 16'sd0 : mc[c_load_row][i];
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        logic st;
        logic sl;
        rst_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        acc   = 1'b0;
        #1 rst_n = 1'b0;
        #7;
        n_vec++;
        if ({busy, done, en_o, WrEn_o, step, c_zero, c_load_row, a_valid, b_valid,
             c_out_valid, c_out_row} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: outputs not all zero busy=%b en=%b wren=%b step=%0d",
                     busy, en_o, WrEn_o, step);
        end
        #4 rst_n = 1'b1;

        // Basic op, acc=0, no stalls.
        tick(); drive(1'b1, 1'b0, 1'b0);
        repeat (22) begin tick(); drive(1'b0, 1'b0, 1'b0); end

        // acc=1 with a 3-cycle stall at MAC t=5.
        tick(); drive(1'b1, 1'b0, 1'b1);
        sc = 0;
        for (int i = 0; i < 26; i++) begin
            tick();
            sl = (m_mode == 1) && (m_k == DIM + 5) && (sc < 3);
            if (sl) sc++;
            drive(1'b0, sl, 1'b1);
        end

        // Start pulses during MAC and DONE are ignored.
        tick(); drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick();
            st = ((m_mode == 1) && (m_k == DIM + 2)) || (m_mode == 2);
            drive(st, 1'b0, 1'b0);
        end

        // Start held high: back-to-back ops.
        for (int i = 0; i < 45; i++) begin tick(); drive(1'b1, 1'b0, 1'b1); end
        for (int i = 0; i < 25; i++) begin tick(); drive(1'b0, 1'b0, 1'b0); end

        // Reset asserted between edges mid-DRAIN.
        tick(); drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_mode == 1 && m_k == DIM + MACN + 1) break;
            drive(1'b0, 1'b0, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, en_o, WrEn_o, c_out_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_mid_drain: busy=%b done=%b en=%b wren=%b cov=%b expected all 0",
                     busy, done, en_o, WrEn_o, c_out_valid);
        end
        start  = 1'b0;
        stall  = 1'b0;
        m_mode = 0;
        row_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(); drive(1'b0, 1'b0, 1'b0);
        tick(); drive(1'b1, 1'b0, 1'b1);
        repeat (22) begin tick(); drive(1'b0, 1'b0, 1'b0); end

        // Randomized starts, stalls and acc.
        for (int i = 0; i < 400; i++) begin
            tick();
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++) begin tick(); drive(1'b0, 1'b0, 1'b0); end
        tick();
        @(negedge clk);
        #1;

        n_vec++;
        if (row_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: rows pending %0d expected 0, ctl pending %0d expected 0",
                     row_q.size(), exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
